mole_spawner: RTL

- Mole generator and hit-detection stage for the whack-a-mole reaction game.
- Sits directly downstream of the game control FSM: consumes `play_flag` and `new_mole`, and produces `mole_complete` back to it.
- Picks a pseudo-random hole, lights it, times its lifetime, detects a hit or timeout, and keeps the score.
- Each hit shortens the lifetime, so difficulty ramps up.

---
 rtl/mole_spawner.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: lights an LFSR-chosen hole, times it, detects hits/timeouts, keeps score.
// Optional build macro MOLE_PENALTY_EN: wrong-button edges while a mole is up cost a point.
module mole_spawner #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int NUM_HOLES   = 8,
  parameter int MOLE_MS_MAX = 2000,
  parameter int MOLE_MS_MIN = 500,
  parameter int STEP_MS     = 100,
  parameter int GAP_MS      = 300
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 play_flag,
  input  logic                 new_mole,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [NUM_HOLES-1:0] mole_leds,
  output logic                 mole_complete,
  output logic                 hit,
  output logic                 miss,
  output logic [15:0]          score,
  output logic [11:0]          lifetime_ms
);

  localparam int TICK_DIV = ((CLK_FREQ_HZ / 1000) < 1) ? 1 : (CLK_FREQ_HZ / 1000);
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW       = $clog2(NUM_HOLES);

  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [11:0]   GAP_CNT    = 12'(GAP_MS);
  localparam logic [11:0]   LIFE_MAX   = 12'(MOLE_MS_MAX);
  localparam logic [12:0]   LIFE_MIN   = 13'(MOLE_MS_MIN);
  localparam logic [12:0]   LIFE_STEP  = 13'(STEP_MS);
  localparam logic [HW-1:0] HOLE_LAST  = HW'(NUM_HOLES - 1);
  localparam logic [HW-1:0] HOLE_ONE   = HW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // 13-bit subtraction so a step larger than the current lifetime still floors cleanly.
  function automatic logic [11:0] shorten(input logic [11:0] life);
    logic [12:0] diff;
    diff = {1'b0, life} - LIFE_STEP;
    if (diff[12] || (diff < LIFE_MIN)) begin
      return LIFE_MIN[11:0];
    end else begin
      return diff[11:0];
    end
  endfunction

  function automatic logic [NUM_HOLES-1:0] onehot(input logic [HW-1:0] idx);
    logic [NUM_HOLES-1:0] v;
    v      = {NUM_HOLES{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t                state_r, state_nxt_s;
  logic                  entry_r;
  logic [15:0]           lfsr_r;
  logic [PW-1:0]         presc_r;
  logic                  tick_s;
  logic [11:0]           ms_cnt_r;
  logic [NUM_HOLES-1:0]  btn_r, btn_prev_r, btn_edge_s, lit_s;
  logic                  play_prev_r, play_rise_s;
  logic [HW-1:0]         hole_r, hole_nxt_s, pick_raw_s, pick_s;
  logic                  hole_valid_r, hole_valid_nxt_s;
  logic                  hit_ok_s, penalty_s, timeout_s;
  logic [NUM_HOLES-1:0]  leds_r, leds_nxt_s;
  logic                  hit_r, hit_nxt_s, miss_r, miss_nxt_s, done_r, done_nxt_s;
  logic [15:0]           score_r, score_nxt_s;
  logic [11:0]           life_r, life_nxt_s;

  assign tick_s      = (presc_r == TICK_LAST);
  assign btn_edge_s  = btn_r & ~btn_prev_r;
  assign lit_s       = onehot(hole_r);
  assign play_rise_s = play_flag & ~play_prev_r;
  assign timeout_s   = (ms_cnt_r == life_r);
  assign pick_raw_s  = HW'(lfsr_r % 16'(NUM_HOLES));

  // Hole choice: a repeat of the previous hole is bumped to the next one.
  always_comb begin
    pick_s = pick_raw_s;
    if (hole_valid_r && (pick_raw_s == hole_r)) begin
      if (pick_raw_s == HOLE_LAST) begin
        pick_s = {HW{1'b0}};
      end else begin
        pick_s = pick_raw_s + HOLE_ONE;
      end
    end else begin
      pick_s = pick_raw_s;
    end
  end

  // Classify this cycle's button edges against the lit hole.
  always_comb begin
    hit_ok_s  = |(btn_edge_s & lit_s);
    penalty_s = 1'b0;
`ifdef MOLE_PENALTY_EN
    if (|(btn_edge_s & ~lit_s)) begin
      hit_ok_s  = 1'b0;
      penalty_s = 1'b1;
    end else begin
      penalty_s = 1'b0;
    end
`endif
  end

  // Next-state logic; play_flag low always wins outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (play_rise_s) state_nxt_s = GAP;
        else             state_nxt_s = IDLE;
      end
      GAP: begin
        if (!play_flag)              state_nxt_s = IDLE;
        else if (ms_cnt_r == GAP_CNT) state_nxt_s = UP;
        else                         state_nxt_s = GAP;
      end
      UP: begin
        if (!play_flag)                state_nxt_s = IDLE;
        else if (hit_ok_s || timeout_s) state_nxt_s = DONE;
        else                           state_nxt_s = UP;
      end
      DONE: begin
        if (!play_flag)    state_nxt_s = IDLE;
        else if (new_mole) state_nxt_s = GAP;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched hole.
  always_comb begin
    hit_nxt_s        = 1'b0;
    miss_nxt_s       = 1'b0;
    done_nxt_s       = 1'b0;
    score_nxt_s      = score_r;
    life_nxt_s       = life_r;
    hole_nxt_s       = hole_r;
    hole_valid_nxt_s = hole_valid_r;
    leds_nxt_s       = {NUM_HOLES{1'b0}};
    case (state_r)
      IDLE: begin
        if (play_rise_s) begin
          score_nxt_s = 16'd0;
          life_nxt_s  = LIFE_MAX;
        end else begin
          score_nxt_s = score_r;
          life_nxt_s  = life_r;
        end
      end
      GAP: begin
        if (state_nxt_s == UP) begin
          hole_nxt_s       = pick_s;
          hole_valid_nxt_s = 1'b1;
        end else begin
          hole_nxt_s       = hole_r;
          hole_valid_nxt_s = hole_valid_r;
        end
      end
      UP: begin
        if (play_flag) begin
          hit_nxt_s  = hit_ok_s;
          miss_nxt_s = penalty_s | (timeout_s & ~hit_ok_s);
          if (hit_ok_s) begin
            score_nxt_s = (score_r == 16'hFFFF) ? score_r : (score_r + 16'd1);
            life_nxt_s  = shorten(life_r);
          end else if (penalty_s) begin
            score_nxt_s = (score_r == 16'd0) ? score_r : (score_r - 16'd1);
          end else begin
            score_nxt_s = score_r;
          end
        end else begin
          hit_nxt_s  = 1'b0;
          miss_nxt_s = 1'b0;
        end
      end
      DONE: begin
        done_nxt_s = entry_r & play_flag;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
    if (state_nxt_s == UP) begin
      leds_nxt_s = onehot(hole_nxt_s);
    end else begin
      leds_nxt_s = {NUM_HOLES{1'b0}};
    end
  end

  // State register plus a first-cycle-in-state flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      entry_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      entry_r <= (state_nxt_s != state_r);
    end
  end

  // Timers, LFSR, input history and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_r       <= 16'hACE1;
      presc_r      <= {PW{1'b0}};
      ms_cnt_r     <= 12'd0;
      btn_r        <= {NUM_HOLES{1'b0}};
      btn_prev_r   <= {NUM_HOLES{1'b0}};
      play_prev_r  <= 1'b0;
      hole_r       <= {HW{1'b0}};
      hole_valid_r <= 1'b0;
      leds_r       <= {NUM_HOLES{1'b0}};
      hit_r        <= 1'b0;
      miss_r       <= 1'b0;
      done_r       <= 1'b0;
      score_r      <= 16'd0;
      life_r       <= LIFE_MAX;
    end else begin
      lfsr_r      <= lfsr_step(lfsr_r);
      btn_r       <= buttons;
      btn_prev_r  <= btn_r;
      play_prev_r <= play_flag;
      if (state_nxt_s != state_r) begin
        presc_r  <= {PW{1'b0}};
        ms_cnt_r <= 12'd0;
      end else begin
        presc_r <= tick_s ? {PW{1'b0}} : (presc_r + PRESC_ONE);
        if (tick_s && ((state_r == GAP) || (state_r == UP))) begin
          ms_cnt_r <= ms_cnt_r + 12'd1;
        end else begin
          ms_cnt_r <= ms_cnt_r;
        end
      end
      hole_r       <= hole_nxt_s;
      hole_valid_r <= hole_valid_nxt_s;
      leds_r       <= leds_nxt_s;
      hit_r        <= hit_nxt_s;
      miss_r       <= miss_nxt_s;
      done_r       <= done_nxt_s;
      score_r      <= score_nxt_s;
      life_r       <= life_nxt_s;
    end
  end

  assign mole_leds     = leds_r;
  assign mole_complete = done_r;
  assign hit           = hit_r;
  assign miss          = miss_r;
  assign score         = score_r;
  assign lifetime_ms   = life_r;

endmodule
